// File: rtl/modulo_updown_counter.sv
// -----------------------------------------------------------------------------
// modulo_updown_counter
//
// Purpose:
//   An up/down counter with a programmable modulus (MAX_VAL+1). It can either
//   wrap or saturate at the bounds. An enable prescaler sets how many enabled
//   cycles make up one count step. A registered terminal-count pulse (tc) is
//   raised for one cycle after any step taken at a bound.
//
// Parameters:
//   WIDTH     counter width in bits (>=1)
//   MAX_VAL   highest count value, 1 <= MAX_VAL <= 2**WIDTH-1
//   PRESCALE  enabled cycles per count step (>=1)
//   SATURATE  0: wrap at the bounds, 1: hold at the bounds
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-high
//   load     in   1      synchronous load of cnt_in (clamped to MAX_VAL)
//   enable   in   1      count enable; gates the prescaler
//   up_dn    in   1      1 = count up, 0 = count down
//   cnt_in   in   WIDTH  load value
//   cnt_out  out  WIDTH  current count, registered
//   tc       out  1      registered pulse after a step taken at a bound
//   at_max   out  1      cnt_out == MAX_VAL
//   at_min   out  1      cnt_out == 0
// -----------------------------------------------------------------------------
module modulo_updown_counter #(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  // The prescaler is always at least one bit wide. With PRESCALE=1 its last
  // phase is 0, so every enabled cycle is a step.
  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [PS_W-1:0]  r_ps;
  logic             r_tc;

  logic             w_step;
  logic             w_bound;
  logic [WIDTH-1:0] w_cnt_step;
  logic [WIDTH-1:0] w_load_val;

  assign w_step     = enable && (r_ps == PS_LAST);
  // Values above MAX_VAL would fall outside the modulus, so they are clamped.
  assign w_load_val = (cnt_in > MAX_V) ? MAX_V : cnt_in;

  // Next count for a step. All arithmetic stays within 0..MAX_VAL. It never
  // relies on the natural 2**WIDTH rollover.
  always_comb begin
    // NOTE: every output of this block gets a default first. Otherwise a
    // branch that skips an assignment would infer a latch.
    w_cnt_step = r_cnt;
    w_bound    = 1'b0;
    if (up_dn) begin
      if (r_cnt == MAX_V) begin
        w_bound    = 1'b1;
        w_cnt_step = (SATURATE != 0) ? MAX_V : '0;
      end else begin
        w_cnt_step = r_cnt + 1'b1;
      end
    end else begin
      if (r_cnt == '0) begin
        w_bound    = 1'b1;
        w_cnt_step = (SATURATE != 0) ? '0 : MAX_V;
      end else begin
        w_cnt_step = r_cnt - 1'b1;
      end
    end
  end

  // Priority on each edge: rst > load > enable > hold. tc defaults low on
  // every non-reset edge. It is raised only by a step taken at a bound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, independent of statement order.
      r_cnt <= '0;
      r_ps  <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_cnt <= w_load_val;
      r_ps  <= '0;
      r_tc  <= 1'b0;
    end else if (enable) begin
      if (w_step) begin
        r_cnt <= w_cnt_step;
        r_ps  <= '0;
        r_tc  <= w_bound;
      end else begin
        r_ps  <= r_ps + 1'b1;
        r_tc  <= 1'b0;
      end
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign cnt_out = r_cnt;
  assign tc      = r_tc;
  assign at_max  = (r_cnt == MAX_V);
  assign at_min  = (r_cnt == '0);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_modulo_updown_counter
//
// Three instances with MAX_VAL=23 and WIDTH=5:
//   u0: wrap,     PRESCALE=1
//   u1: saturate, PRESCALE=1
//   u2: wrap,     PRESCALE=3
// The stimulus process drives one cycle at a time. After each active edge it
// pushes the hand-computed count and tc into a scoreboard queue. A monitor
// pops the queue on the falling edge and compares against the outputs.
// -----------------------------------------------------------------------------
module tb_modulo_updown_counter;

  typedef struct {
    int         id;
    logic [4:0] cnt;
    logic       tc;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v    [3];
  logic       load_v   [3];
  logic       enable_v [3];
  logic       up_dn_v  [3];
  logic [4:0] cnt_in_v [3];
  logic [4:0] cnt_o    [3];
  logic       tc_o     [3];
  logic       amax_o   [3];
  logic       amin_o   [3];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  modulo_updown_counter #(.WIDTH(5), .MAX_VAL(23), .PRESCALE(1), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .load(load_v[0]), .enable(enable_v[0]),
    .up_dn(up_dn_v[0]), .cnt_in(cnt_in_v[0]), .cnt_out(cnt_o[0]), .tc(tc_o[0]),
    .at_max(amax_o[0]), .at_min(amin_o[0]));

  modulo_updown_counter #(.WIDTH(5), .MAX_VAL(23), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .load(load_v[1]), .enable(enable_v[1]),
    .up_dn(up_dn_v[1]), .cnt_in(cnt_in_v[1]), .cnt_out(cnt_o[1]), .tc(tc_o[1]),
    .at_max(amax_o[1]), .at_min(amin_o[1]));

  modulo_updown_counter #(.WIDTH(5), .MAX_VAL(23), .PRESCALE(3), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .load(load_v[2]), .enable(enable_v[2]),
    .up_dn(up_dn_v[2]), .cnt_in(cnt_in_v[2]), .cnt_out(cnt_o[2]), .tc(tc_o[2]),
    .at_max(amax_o[2]), .at_min(amin_o[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so on the falling edge they hold the
  // result of the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".cnt"},    32'(cnt_o[e.id]),  32'(e.cnt));
      check({e.name, ".tc"},     32'(tc_o[e.id]),   32'(e.tc));
      check({e.name, ".at_max"}, 32'(amax_o[e.id]), (e.cnt == 5'd23) ? 32'd1 : 32'd0);
      check({e.name, ".at_min"}, 32'(amin_o[e.id]), (e.cnt == 5'd0)  ? 32'd1 : 32'd0);
    end
  end

  // One cycle of stimulus followed by the expected post-edge state.
  task automatic step(input int id, input logic ld, input logic en, input logic ud,
                      input logic [4:0] cin, input logic [4:0] ec, input logic et,
                      input string nm);
    @(negedge clk);
    load_v[id]   = ld;
    enable_v[id] = en;
    up_dn_v[id]  = ud;
    cnt_in_v[id] = cin;
    @(posedge clk);
    sb.push_back('{id: id, cnt: ec, tc: et, name: nm});
  endtask

  // Pulse reset between clock edges. The outputs must clear before the next edge.
  task automatic mid_reset(input int id, input string nm);
    @(negedge clk);
    load_v[id]   = 1'b0;
    enable_v[id] = 1'b0;
    #2 rst_v[id] = 1'b1;
    #1;
    check({nm, ".cnt"},    32'(cnt_o[id]),  32'd0);
    check({nm, ".tc"},     32'(tc_o[id]),   32'd0);
    check({nm, ".at_min"}, 32'(amin_o[id]), 32'd1);
    check({nm, ".at_max"}, 32'(amax_o[id]), 32'd0);
    @(negedge clk);
    rst_v[id] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; load_v[i] = 1'b0; enable_v[i] = 1'b0;
      up_dn_v[i] = 1'b1; cnt_in_v[i] = 5'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset.cnt",    32'(cnt_o[i]),  32'd0);
      check("reset.tc",     32'(tc_o[i]),   32'd0);
      check("reset.at_min", 32'(amin_o[i]), 32'd1);
      check("reset.at_max", 32'(amax_o[i]), 32'd0);
      rst_v[i] = 1'b0;
    end

    // u0: load and clamp
    step(0, 1, 0, 1, 5'h15, 5'd21, 0, "load21");
    step(0, 1, 0, 1, 5'h1F, 5'd23, 0, "load_clamp");
    step(0, 1, 0, 0, 5'd23, 5'd23, 0, "load_max_exact");
    // u0: wrap up
    step(0, 1, 0, 1, 5'd22, 5'd22, 0, "load22");
    step(0, 0, 1, 1, 5'd0,  5'd23, 0, "up_to_max");
    step(0, 0, 1, 1, 5'd0,  5'd0,  1, "wrap_up");
    step(0, 0, 1, 1, 5'd0,  5'd1,  0, "up_after_wrap");
    // u0: direction change, wrap down
    step(0, 0, 1, 0, 5'd0,  5'd0,  0, "down_to_min");
    step(0, 0, 1, 0, 5'd0,  5'd23, 1, "wrap_down");
    step(0, 0, 1, 0, 5'd0,  5'd22, 0, "down_after_wrap");
    step(0, 0, 0, 1, 5'd0,  5'd22, 0, "hold");
    // u0: async reset mid-count, then with tc high
    step(0, 1, 0, 1, 5'd17, 5'd17, 0, "load17");
    mid_reset(0, "rst_at17");
    step(0, 1, 0, 0, 5'd0,  5'd0,  0, "load0");
    step(0, 0, 1, 0, 5'd0,  5'd23, 1, "tc_before_rst");
    mid_reset(0, "rst_with_tc");
    step(0, 1, 1, 1, 5'd5,  5'd5,  0, "load_wins");

    // u1: saturate
    step(1, 1, 0, 1, 5'd22, 5'd22, 0, "sat_load22");
    step(1, 0, 1, 1, 5'd0,  5'd23, 0, "sat_up1");
    step(1, 0, 1, 1, 5'd0,  5'd23, 1, "sat_up2");
    step(1, 0, 1, 1, 5'd0,  5'd23, 1, "sat_up3");
    step(1, 0, 1, 0, 5'd0,  5'd22, 0, "sat_down");
    step(1, 1, 0, 0, 5'd0,  5'd0,  0, "sat_load0");
    step(1, 0, 1, 0, 5'd0,  5'd0,  1, "sat_down_min");
    step(1, 0, 1, 1, 5'd0,  5'd1,  0, "sat_up_from_min");

    // u2: prescale by 3
    step(2, 1, 0, 1, 5'd0,  5'd0,  0, "ps_load0");
    step(2, 0, 1, 1, 5'd0,  5'd0,  0, "ps_c1");
    step(2, 0, 1, 1, 5'd0,  5'd0,  0, "ps_c2");
    step(2, 0, 1, 1, 5'd0,  5'd1,  0, "ps_c3");
    step(2, 0, 1, 1, 5'd0,  5'd1,  0, "ps_c4");
    step(2, 0, 1, 1, 5'd0,  5'd1,  0, "ps_c5");
    step(2, 0, 1, 1, 5'd0,  5'd2,  0, "ps_c6");
    step(2, 0, 1, 1, 5'd0,  5'd2,  0, "ps_phase1");
    step(2, 0, 0, 1, 5'd0,  5'd2,  0, "ps_freeze1");
    step(2, 0, 0, 1, 5'd0,  5'd2,  0, "ps_freeze2");
    step(2, 0, 1, 1, 5'd0,  5'd2,  0, "ps_phase2");
    step(2, 0, 1, 1, 5'd0,  5'd3,  0, "ps_resume_step");
    step(2, 0, 1, 1, 5'd0,  5'd3,  0, "ps_phase1b");
    step(2, 1, 0, 1, 5'd10, 5'd10, 0, "ps_load_clears");
    step(2, 0, 1, 1, 5'd0,  5'd10, 0, "ps_after_load1");
    step(2, 0, 1, 1, 5'd0,  5'd10, 0, "ps_after_load2");
    step(2, 0, 1, 1, 5'd0,  5'd11, 0, "ps_after_load3");
    step(2, 1, 0, 1, 5'd23, 5'd23, 0, "ps_load23");
    step(2, 0, 1, 1, 5'd0,  5'd23, 0, "ps_wrap1");
    step(2, 0, 1, 1, 5'd0,  5'd23, 0, "ps_wrap2");
    step(2, 0, 1, 1, 5'd0,  5'd0,  1, "ps_wrap3");

    // Let the monitor drain the last entry.
    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
